// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed SDF frame in, natural-order N-cycle burst out.
// Latency 2 cycles from the frame's last input to its first output; no backpressure, every di_en sample is accepted.
module fft_bitrev_reorder #(
    parameter int N     = 128,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);
    localparam int AW = $clog2(N);

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [AW-1:0]    wc_q, wc_d;
    logic [AW-1:0]    rc_q, rc_d;
    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic             req_q, req_d;
    logic             req_bank_q, req_bank_d;
    logic             do_en_q, do_en_d;
    logic [WIDTH-1:0] do_re_q, do_re_d;
    logic [WIDTH-1:0] do_im_q, do_im_d;

    logic [WIDTH-1:0] mem_re [2*N];
    logic [WIDTH-1:0] mem_im [2*N];

    logic             wr_en;
    logic             frame_done;
    logic [AW:0]      waddr;
    logic [AW:0]      raddr;
    logic [WIDTH-1:0] rd_re;
    logic [WIDTH-1:0] rd_im;

    always_comb begin
        wr_en      = di_en & ~rst;
        frame_done = wr_en && (wc_q == AW'(N - 1));
        waddr      = {wb_q, bitrev(wc_q)};
        raddr      = {rb_q, rc_q};
        rd_re      = mem_re[raddr];
        rd_im      = mem_im[raddr];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[waddr] <= di_re;
            mem_im[waddr] <= di_im;
        end
    end

    always_comb begin
        state_d    = state_q;
        wc_d       = wc_q;
        rc_d       = rc_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        req_d      = req_q;
        req_bank_d = req_bank_q;
        do_en_d    = 1'b0;
        do_re_d    = do_re_q;
        do_im_d    = do_im_q;

        if (wr_en) begin
            wc_d = wc_q + AW'(1);
        end

        case (state_q)
            IDLE: begin
                if (req_q) begin
                    state_d = READ;
                    rc_d    = '0;
                    rb_d    = req_bank_q;
                    req_d   = 1'b0;
                end
            end
            READ: begin
                do_en_d = 1'b1;
                do_re_d = rd_re;
                do_im_d = rd_im;
                rc_d    = rc_q + AW'(1);
                if (rc_q == AW'(N - 1)) begin
                    // A frame that completed during this readout starts with no bubble.
                    rc_d = '0;
                    if (req_q) begin
                        rb_d  = req_bank_q;
                        req_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Posting wins over consumption; the bank to read is captured with the request
        // because wb may toggle again before the readout of this frame ends.
        if (frame_done) begin
            wb_d       = ~wb_q;
            req_d      = 1'b1;
            req_bank_d = wb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wc_q       <= '0;
            rc_q       <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            req_q      <= 1'b0;
            req_bank_q <= 1'b0;
            do_en_q    <= 1'b0;
            do_re_q    <= '0;
            do_im_q    <= '0;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            rc_q       <= rc_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            req_q      <= req_d;
            req_bank_q <= req_bank_d;
            do_en_q    <= do_en_d;
            do_re_q    <= do_re_d;
            do_im_q    <= do_im_d;
        end
    end

    assign do_en = do_en_q;
    assign do_re = do_re_q;
    assign do_im = do_im_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: queue-based frame model for N=8 checked every cycle, plus literal N=128 spot checks.
module tb_fft_bitrev_reorder;
    logic        clk = 1'b0;
    logic        rst;
    logic        di_en8, do_en8;
    logic [15:0] di_re8, di_im8, do_re8, do_im8;
    logic        di_en128, do_en128;
    logic [15:0] di_re128, di_im128, do_re128, do_im128;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.N(8), .WIDTH(16)) dut8 (
        .clk(clk), .rst(rst),
        .di_en(di_en8), .di_re(di_re8), .di_im(di_im8),
        .do_en(do_en8), .do_re(do_re8), .do_im(do_im8)
    );

    fft_bitrev_reorder #(.N(128), .WIDTH(16)) dut128 (
        .clk(clk), .rst(rst),
        .di_en(di_en128), .di_re(di_re128), .di_im(di_im128),
        .do_en(do_en128), .do_re(do_re128), .do_im(do_im128)
    );

    typedef struct {
        int          cyc;
        logic [15:0] re;
        logic [15:0] im;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    exp_t        exp_q[$];
    logic [15:0] frm_re[8];
    logic [15:0] frm_im[8];
    logic [15:0] out_re[8];
    logic [15:0] out_im[8];
    int          fill = 0;
    logic [15:0] last_re = '0;
    logic [15:0] last_im = '0;
    int          cap_re[$];
    int          cap_im[$];
    int          cap_cyc[$];
    int          cap128_re[$];
    int          cap128_im[$];
    int          first128 = -1;
    int          acc;
    int          acc128;

    function automatic int bitrev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            if (v[i]) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Model: a full frame of 8 accepted samples yields out[bitrev(w)] = in[w], shown from edge E0+2 onward.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            exp_q.delete();
            fill    = 0;
            last_re = '0;
            last_im = '0;
        end else if (di_en8) begin
            frm_re[fill] = di_re8;
            frm_im[fill] = di_im8;
            fill++;
            if (fill == 8) begin
                for (int w = 0; w < 8; w++) begin
                    out_re[bitrev(w, 3)] = frm_re[w];
                    out_im[bitrev(w, 3)] = frm_im[w];
                end
                for (int k = 0; k < 8; k++) begin
                    e.cyc = cyc + 2 + k;
                    e.re  = out_re[k];
                    e.im  = out_im[k];
                    exp_q.push_back(e);
                end
                fill = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("do_en burst", 32'(do_en8), 32'd1);
                chk("do_re", 32'(do_re8), 32'(exp_q[0].re));
                chk("do_im", 32'(do_im8), 32'(exp_q[0].im));
                last_re = exp_q[0].re;
                last_im = exp_q[0].im;
                void'(exp_q.pop_front());
            end else begin
                chk("do_en idle", 32'(do_en8), 32'd0);
                chk("do_re hold", 32'(do_re8), 32'(last_re));
                chk("do_im hold", 32'(do_im8), 32'(last_im));
            end
            if (do_en8 === 1'b1) begin
                cap_re.push_back(int'(do_re8));
                cap_im.push_back(int'(do_im8));
                cap_cyc.push_back(cyc);
            end
            if (do_en128 === 1'b1) begin
                if (cap128_re.size() == 0) first128 = cyc;
                cap128_re.push_back(int'(do_re128));
                cap128_im.push_back(int'(do_im128));
            end
        end
    end

    task automatic send8(input int v);
        @(posedge clk); #1;
        di_en8 = 1'b1;
        di_re8 = 16'(v);
        di_im8 = 16'(v + 100);
        acc    = cyc + 1;
    endtask

    task automatic idle8();
        @(posedge clk); #1;
        di_en8 = 1'b0;
    endtask

    task automatic clear_cap();
        cap_re.delete();
        cap_im.delete();
        cap_cyc.delete();
    endtask

    task automatic check_pat(input string nm, input int ofs, input int base, input int cnt);
        int pat[8];
        pat = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int i = 0; i < cnt; i++) begin
            if (ofs + i < cap_re.size()) begin
                chk({nm, " re"}, 32'(cap_re[ofs + i]), 32'(base + pat[i]));
                chk({nm, " im"}, 32'(cap_im[ofs + i]), 32'(base + 100 + pat[i]));
            end else begin
                chk({nm, " missing"}, 32'(cap_re.size()), 32'(ofs + i + 1));
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        di_en8   = 1'b0; di_re8   = '0; di_im8   = '0;
        di_en128 = 1'b0; di_re128 = '0; di_im128 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset do_en", 32'(do_en8), 32'd0);
        chk("reset do_re", 32'(do_re8), 32'd0);
        chk("reset do_im", 32'(do_im8), 32'd0);

        // Single contiguous frame
        clear_cap();
        for (int i = 0; i < 8; i++) send8(i);
        idle8();
        repeat (15) @(posedge clk);
        chk("single count", 32'(cap_re.size()), 32'd8);
        check_pat("single", 0, 0, 8);
        if (cap_cyc.size() == 8) begin
            chk("single latency", 32'(cap_cyc[0]), 32'(acc + 2));
            chk("single contiguous", 32'(cap_cyc[7] - cap_cyc[0]), 32'd7);
        end

        // Gapped input: valid every other cycle
        clear_cap();
        for (int i = 0; i < 8; i++) begin
            send8(i);
            idle8();
        end
        repeat (15) @(posedge clk);
        chk("gapped count", 32'(cap_re.size()), 32'd8);
        check_pat("gapped", 0, 0, 8);
        if (cap_cyc.size() == 8) begin
            chk("gapped latency", 32'(cap_cyc[0]), 32'(acc + 2));
            chk("gapped contiguous", 32'(cap_cyc[7] - cap_cyc[0]), 32'd7);
        end

        // Three back-to-back frames
        clear_cap();
        for (int i = 0; i < 24; i++) send8(i);
        idle8();
        repeat (20) @(posedge clk);
        chk("b2b count", 32'(cap_re.size()), 32'd24);
        check_pat("b2b f1", 0, 0, 8);
        check_pat("b2b f2", 8, 8, 8);
        check_pat("b2b f3", 16, 16, 8);
        if (cap_cyc.size() == 24) begin
            chk("b2b contiguous", 32'(cap_cyc[23] - cap_cyc[0]), 32'd23);
        end

        // Reset mid-write; di_en held high during reset must be ignored
        clear_cap();
        for (int i = 0; i < 5; i++) send8(30 + i);
        @(posedge clk); #1;
        rst = 1'b1; di_en8 = 1'b1; di_re8 = 16'd99; di_im8 = 16'd199;
        @(posedge clk); #1;
        rst = 1'b0; di_en8 = 1'b0;
        for (int i = 0; i < 8; i++) send8(50 + i);
        idle8();
        repeat (15) @(posedge clk);
        chk("midwrite count", 32'(cap_re.size()), 32'd8);
        check_pat("midwrite", 0, 50, 8);

        // Reset during the 4th output cycle
        clear_cap();
        for (int i = 0; i < 8; i++) send8(i);
        idle8();
        for (int t = 0; t < 40 && cap_re.size() < 4; t++) begin
            @(negedge clk); #2;
        end
        chk("midread reached", 32'(cap_re.size()), 32'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        chk("midread count", 32'(cap_re.size()), 32'd4);
        check_pat("midread", 0, 0, 4);
        chk("midread drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("midread do_re", 32'(do_re8), 32'd0);

        // Default size N=128, di_re = w
        for (int w = 0; w < 128; w++) begin
            @(posedge clk); #1;
            di_en128 = 1'b1;
            di_re128 = 16'(w);
            di_im128 = 16'(w + 1000);
            acc128   = cyc + 1;
        end
        @(posedge clk); #1;
        di_en128 = 1'b0;
        for (int t = 0; t < 300 && cap128_re.size() < 128; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("n128 count", 32'(cap128_re.size()), 32'd128);
        chk("n128 latency", 32'(first128), 32'(acc128 + 2));
        if (cap128_re.size() == 128) begin
            chk("n128 k=1", 32'(cap128_re[1]), 32'd64);
            chk("n128 k=127", 32'(cap128_re[127]), 32'd127);
            chk("n128 k=2", 32'(cap128_re[2]), 32'd32);
            for (int k = 0; k < 128; k++) begin
                chk("n128 re", 32'(cap128_re[k]), 32'(bitrev(k, 7)));
                chk("n128 im", 32'(cap128_im[k]), 32'(bitrev(k, 7) + 1000));
            end
        end

        chk("final drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
